pla_al2_encoder: RTL and testbench

PLA_AL2_ENCODER -- requirements
Module: pla_al2_encoder

---
 rtl/pla_al2_encoder.sv | 152 +++++++++++++++
 tb/tb_pla_al2_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pla_al2_encoder.sv
// Three-field one-hot priority encoder feeding a small output FIFO.
// Each entry carries the codes plus per-field error flags; a saturating counter tracks error beats.
module pla_al2_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERRCNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [15:0]                 sel_a,
  input  logic [15:0]                 sel_b,
  input  logic [7:0]                  sel_c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3:0]                  code_a,
  output logic [3:0]                  code_b,
  output logic [2:0]                  code_c,
  output logic [2:0]                  out_err,
  input  logic                        err_clr,
  output logic [ERRCNT_W-1:0]         err_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 14;

  // Lowest set bit wins; an all-zero field encodes to 0.
  function automatic logic [3:0] enc16(input logic [15:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        c = 4'(i);
      end
    end
    return c;
  endfunction

  function automatic logic bad16(input logic [15:0] v);
    return (v == 16'd0) || ((v & (v - 16'd1)) != 16'd0);
  endfunction

  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [EW-1:0]       head_q, head_d;
  logic [LW-1:0]       level_q, level_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_s;
  logic                ready_q, ready_d, valid_q, valid_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]          enc_c_wide_s;
  logic [2:0]          err_s;
  logic [EW-1:0]       wr_entry_s;
  logic                push_s, pop_s;

  // Encode the incoming beat and compute all next-state values.
  always_comb begin
    enc_c_wide_s = enc16({8'd0, sel_c});
    err_s        = {bad16({8'd0, sel_c}), bad16(sel_b), bad16(sel_a)};
    wr_entry_s   = {err_s, enc_c_wide_s[2:0], enc16(sel_b), enc16(sel_a)};
    push_s       = in_valid & ready_q;
    pop_s        = valid_q & out_ready;
    rd_next_s    = rd_ptr_q + PW'(1);
    level_d      = level_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    head_d       = head_q;
    err_cnt_d    = err_cnt_q;

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_next_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // The head register mirrors the oldest entry so outputs never see the RAM read path.
    if (level_d == LW'(0)) begin
      head_d = '0;
    end else if (pop_s) begin
      if (level_q == LW'(1)) begin
        head_d = wr_entry_s;
      end else begin
        head_d = mem_q[rd_next_s];
      end
    end else if (level_q == LW'(0)) begin
      head_d = wr_entry_s;
    end else begin
      head_d = head_q;
    end

    if (err_clr) begin
      err_cnt_d = '0;
    end else if (push_s && (err_s != 3'd0) && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end

    ready_d = (level_d != LW'(FIFO_DEPTH));
    valid_d = (level_d != LW'(0));
  end

  // Control state; ready stays low in reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      head_q    <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      head_q    <= head_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: level and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign code_a     = head_q[3:0];
  assign code_b     = head_q[7:4];
  assign code_c     = head_q[10:8];
  assign out_err    = head_q[13:11];
  assign err_cnt    = err_cnt_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_pla_al2_encoder.sv
// Directed bench for pla_al2_encoder: a default instance plus a 2-bit error-counter instance
// sharing the same stimulus.
module tb_pla_al2_encoder;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, err_clr;
  logic [15:0] sel_a, sel_b;
  logic [7:0]  sel_c;

  logic       in_ready, out_valid;
  logic [3:0] code_a, code_b;
  logic [2:0] code_c, out_err;
  logic [7:0] err_cnt;
  logic [2:0] fifo_level;

  logic       s_in_ready, s_out_valid;
  logic [3:0] s_code_a, s_code_b;
  logic [2:0] s_code_c, s_out_err;
  logic [1:0] s_err_cnt;
  logic [2:0] s_fifo_level;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pla_al2_encoder #(.FIFO_DEPTH(4), .ERRCNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .out_valid(out_valid),
    .out_ready(out_ready), .code_a(code_a), .code_b(code_b), .code_c(code_c),
    .out_err(out_err), .err_clr(err_clr), .err_cnt(err_cnt), .fifo_level(fifo_level)
  );

  pla_al2_encoder #(.FIFO_DEPTH(4), .ERRCNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .out_valid(s_out_valid),
    .out_ready(out_ready), .code_a(s_code_a), .code_b(s_code_b), .code_c(s_code_c),
    .out_err(s_out_err), .err_clr(err_clr), .err_cnt(s_err_cnt), .fifo_level(s_fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] c, input logic [2:0] e);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_a"}, {28'd0, code_a}, {28'd0, a});
    chk({tag, "_b"}, {28'd0, code_b}, {28'd0, b});
    chk({tag, "_c"}, {29'd0, code_c}, {29'd0, c});
    chk({tag, "_err"}, {29'd0, out_err}, {29'd0, e});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_level"}, {29'd0, fifo_level}, 32'd0);
    chk({tag, "_codes"}, {18'd0, out_err, code_c, code_b, code_a}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    sel_a = 16'd0; sel_b = 16'd0; sel_c = 8'd0;
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk_empty("rst");
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    #9 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single clean beat, visible one cycle after push.
    in_valid = 1'b1; out_ready = 1'b1;
    sel_a = 16'h0020; sel_b = 16'h8000; sel_c = 8'h01;
    chk("single_no_bypass", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk_head("single", 4'd5, 4'd15, 3'd0, 3'd0);
    chk("single_errcnt", {24'd0, err_cnt}, 32'd0);
    chk("single_level", {29'd0, fifo_level}, 32'd1);
    tick();
    chk_empty("single_drain");

    // Error beat: A empty, B two bits, C clean.
    in_valid = 1'b1;
    sel_a = 16'h0000; sel_b = 16'h0006; sel_c = 8'h80;
    tick();
    in_valid = 1'b0;
    chk_head("errbeat", 4'd0, 4'd1, 3'd7, 3'b011);
    chk("errbeat_cnt", {24'd0, err_cnt}, 32'd1);
    chk("errbeat_cnt_sat", {30'd0, s_err_cnt}, 32'd1);
    tick();
    chk_empty("errbeat_drain");

    // Backpressure: five push attempts into a depth-4 FIFO.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      sel_a = 16'h0001 << k; sel_b = 16'h0001 << (k + 1); sel_c = 8'h01 << k;
      chk("bp_in_ready", {31'd0, in_ready}, (k < 4) ? 32'd1 : 32'd0);
      tick();
      chk("bp_level", {29'd0, fifo_level}, (k < 4) ? k + 1 : 32'd4);
    end
    chk_head("bp_hold", 4'd0, 4'd1, 3'd0, 3'd0);
    // Full FIFO with a pop in the same cycle still refuses the push.
    in_valid = 1'b1; out_ready = 1'b1;
    sel_a = 16'h0200; sel_b = 16'h0200; sel_c = 8'h40;
    tick();
    in_valid = 1'b0;
    chk("bp_full_pop_level", {29'd0, fifo_level}, 32'd3);
    chk("bp_full_pop_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      chk_head("bp_drain", 4'(k), 4'(k + 1), 3'(k), 3'd0);
      tick();
    end
    chk_empty("bp_empty");
    chk("bp_errcnt", {24'd0, err_cnt}, 32'd1);

    // Streaming: one push and one pop per cycle for 20 beats.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      sel_a = 16'h0001 << (i % 16); sel_b = 16'h0001 << ((i + 3) % 16); sel_c = 8'h01 << (i % 8);
      if (i > 0) begin
        chk_head("stream", 4'((i - 1) % 16), 4'((i + 2) % 16), 3'((i - 1) % 8), 3'd0);
        chk("stream_level", {29'd0, fifo_level}, 32'd1);
      end
      tick();
    end
    in_valid = 1'b0;
    chk_head("stream_last", 4'd3, 4'd6, 3'd3, 3'd0);
    tick();
    chk_empty("stream_empty");

    // Saturation: five all-zero (error) beats.
    in_valid = 1'b1;
    sel_a = 16'd0; sel_b = 16'd0; sel_c = 8'd0;
    for (int i = 0; i < 5; i++) tick();
    chk_head("sat_head", 4'd0, 4'd0, 3'd0, 3'b111);
    chk("sat_cnt_2b", {30'd0, s_err_cnt}, 32'd3);
    chk("sat_cnt_8b", {24'd0, err_cnt}, 32'd6);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; in_valid = 1'b0;
    chk("clr_cnt_2b", {30'd0, s_err_cnt}, 32'd0);
    chk("clr_cnt_8b", {24'd0, err_cnt}, 32'd0);
    tick();
    chk_empty("clr_empty");

    // Reset mid-run with three entries queued.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      sel_a = 16'h0400 << k; sel_b = 16'h0400 << k; sel_c = 8'h10 << k;
      tick();
    end
    in_valid = 1'b0;
    chk("mid_level", {29'd0, fifo_level}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_empty("mid_rst");
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk_empty("mid_release");
    chk("mid_release_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1; in_valid = 1'b1;
    sel_a = 16'h0100; sel_b = 16'h0080; sel_c = 8'h02;
    tick();
    in_valid = 1'b0;
    chk_head("mid_new", 4'd8, 4'd7, 3'd1, 3'd0);
    tick();
    chk_empty("mid_final");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
